// File: rtl/dram_bank_responder.sv
// DRAM-side bank responder: 16 banks with open-row tracking, per-bank timing counters,
// command legality checking and a fixed-latency read burst return path.
//
//  state           | meaning
//  B_IDLE          | no row open, ACT allowed
//  B_ACTIVATING    | row captured, waiting tRCD before RD/WR
//  B_ACTIVE        | row open, RD/WR allowed
//  B_PRECHARGING   | closing, waiting tRP before next ACT
module dram_bank_responder #(
    parameter int ROW_W   = 15,
    parameter int COL_W   = 10,
    parameter int T_RCD   = 4,
    parameter int T_RP    = 4,
    parameter int T_RAS   = 10,
    parameter int T_CL    = 6,
    parameter int T_BURST = 8,
    parameter int T_RFC   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd,
    input  logic [1:0]               cmd_bg,
    input  logic [1:0]               cmd_ba,
    input  logic [ROW_W-1:0]         cmd_row,
    input  logic [COL_W-1:0]         cmd_col,
    output logic                     rd_valid,
    output logic [ROW_W+COL_W+6:0]   rd_data,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic [15:0]              bank_open,
    output logic [15:0]              rd_cnt,
    output logic [15:0]              wr_cnt,
    output logic [15:0]              err_cnt
);
    localparam int NB   = 16;
    localparam int TW   = 8;
    localparam int IW   = ROW_W + COL_W + 4;
    localparam int RQ_D = (T_CL + 2 * T_BURST - 1) / T_BURST;
    localparam logic [TW-1:0] ONE = TW'(1);

    localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                           C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6, C_ILL = 3'd7;

    typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_state_t;

    bank_state_t      st_q  [NB];
    bank_state_t      st_d  [NB];
    logic [TW-1:0]    tmr_q [NB];
    logic [TW-1:0]    tmr_d [NB];
    logic [TW-1:0]    ras_q [NB];
    logic [TW-1:0]    ras_d [NB];
    logic [ROW_W-1:0] row_q [NB];
    logic [ROW_W-1:0] row_d [NB];

    logic [TW-1:0]    ref_q, ccd_q;
    logic [3:0]       sel;
    logic [NB-1:0]    is_open, eff_idle, eff_active;
    logic             prea_bad, err_hit, accepted;
    logic [2:0]       err_c;
    logic             do_act, do_rd, do_wr, do_pre, do_prea, do_ref;
    logic             err_pend;
    logic [2:0]       err_pend_code;

    logic             rq_vld  [RQ_D];
    logic [TW-1:0]    rq_cd   [RQ_D];
    logic [IW-1:0]    rq_info [RQ_D];
    logic [RQ_D-1:0]  free_oh;
    logic             start, found;
    logic [IW-1:0]    start_info;
    logic [IW-1:0]    b_info;
    logic [2:0]       b_beat;

    assign sel       = {cmd_bg, cmd_ba};
    assign bank_open = is_open;
    assign rd_data   = rd_valid ? {b_info, b_beat} : '0;

    // "Effective" views fold in timers that expire on this edge, so e.g. RD at ACT+tRCD is legal.
    always_comb begin
        is_open    = '0;
        eff_idle   = '0;
        eff_active = '0;
        prea_bad   = 1'b0;
        for (int i = 0; i < NB; i++) begin
            is_open[i]    = (st_q[i] == B_ACTIVATING) || (st_q[i] == B_ACTIVE);
            eff_active[i] = (st_q[i] == B_ACTIVE) ||
                            ((st_q[i] == B_ACTIVATING) && (tmr_q[i] == '0));
            eff_idle[i]   = (st_q[i] == B_IDLE) ||
                            ((st_q[i] == B_PRECHARGING) && (tmr_q[i] == '0));
            if (is_open[i] && (ras_q[i] != '0)) prea_bad = 1'b1;
        end
    end

    always_comb begin
        err_hit = 1'b0;
        err_c   = 3'd0;
        if (cmd_valid && (cmd != C_NOP)) begin
            if (ref_q != '0) begin
                err_hit = 1'b1; err_c = 3'd7;
            end else begin
                case (cmd)
                    C_ILL: begin err_hit = 1'b1; err_c = 3'd6; end
                    C_ACT: if (!eff_idle[sel]) begin err_hit = 1'b1; err_c = 3'd1; end
                    C_RD, C_WR: begin
                        if (!eff_active[sel]) begin
                            err_hit = 1'b1; err_c = 3'd2;
                        end else if (ccd_q != '0) begin
                            err_hit = 1'b1; err_c = 3'd5;
                        end
                    end
                    C_PRE: if (is_open[sel] && (ras_q[sel] != '0)) begin
                        err_hit = 1'b1; err_c = 3'd3;
                    end
                    C_PREA: if (prea_bad) begin err_hit = 1'b1; err_c = 3'd3; end
                    C_REF:  if (!(&eff_idle)) begin err_hit = 1'b1; err_c = 3'd4; end
                    default: ;
                endcase
            end
        end
    end

    assign accepted = cmd_valid && !err_hit;
    assign do_act   = accepted && (cmd == C_ACT);
    assign do_rd    = accepted && (cmd == C_RD);
    assign do_wr    = accepted && (cmd == C_WR);
    assign do_pre   = accepted && (cmd == C_PRE);
    assign do_prea  = accepted && (cmd == C_PREA);
    assign do_ref   = accepted && (cmd == C_REF);

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = (tmr_q[i] != '0) ? tmr_q[i] - ONE : '0;
            ras_d[i] = (ras_q[i] != '0) ? ras_q[i] - ONE : '0;
            row_d[i] = row_q[i];
            case (st_q[i])
                B_ACTIVATING:  if (tmr_q[i] == '0) st_d[i] = B_ACTIVE;
                B_PRECHARGING: if (tmr_q[i] == '0) st_d[i] = B_IDLE;
                default: ;
            endcase
            if (do_act && (sel == 4'(i))) begin
                st_d[i]  = B_ACTIVATING;
                tmr_d[i] = TW'(T_RCD - 1);
                ras_d[i] = TW'(T_RAS - 1);
                row_d[i] = cmd_row;
            end
            if (((do_pre && (sel == 4'(i))) || do_prea) && is_open[i]) begin
                st_d[i]  = B_PRECHARGING;
                tmr_d[i] = TW'(T_RP - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                st_q[i]  <= B_IDLE;
                tmr_q[i] <= '0;
                ras_q[i] <= '0;
                row_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
                ras_q[i] <= ras_d[i];
                row_q[i] <= row_d[i];
            end
        end
    end

    // Outstanding reads wait in slots; only one can reach zero per edge thanks to tCCD.
    always_comb begin
        start      = 1'b0;
        start_info = '0;
        found      = 1'b0;
        free_oh    = '0;
        for (int i = 0; i < RQ_D; i++) begin
            if (rq_vld[i] && (rq_cd[i] == '0)) begin
                start      = 1'b1;
                start_info = rq_info[i];
            end
            if (!rq_vld[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RQ_D; i++) begin
                rq_vld[i]  <= 1'b0;
                rq_cd[i]   <= '0;
                rq_info[i] <= '0;
            end
            rd_valid      <= 1'b0;
            b_info        <= '0;
            b_beat        <= '0;
            ref_q         <= '0;
            ccd_q         <= '0;
            err_pend      <= 1'b0;
            err_pend_code <= '0;
            err_valid     <= 1'b0;
            err_code      <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            err_cnt       <= '0;
        end else begin
            for (int i = 0; i < RQ_D; i++) begin
                if (do_rd && free_oh[i]) begin
                    rq_vld[i]  <= 1'b1;
                    rq_cd[i]   <= TW'(T_CL - 1);
                    rq_info[i] <= {row_q[sel], cmd_bg, cmd_ba, cmd_col};
                end else if (rq_vld[i]) begin
                    if (rq_cd[i] == '0) rq_vld[i] <= 1'b0;
                    else                rq_cd[i]  <= rq_cd[i] - ONE;
                end
            end

            if (start) begin
                rd_valid <= 1'b1;
                b_info   <= start_info;
                b_beat   <= '0;
            end else if (rd_valid && (b_beat == 3'(T_BURST - 1))) begin
                rd_valid <= 1'b0;
            end else if (rd_valid) begin
                b_beat   <= b_beat + 3'd1;
            end

            if (do_ref)                ref_q <= TW'(T_RFC - 1);
            else if (ref_q != '0)      ref_q <= ref_q - ONE;
            if (do_rd || do_wr)        ccd_q <= TW'(T_BURST - 1);
            else if (ccd_q != '0)      ccd_q <= ccd_q - ONE;

            err_pend      <= err_hit;
            err_pend_code <= err_c;
            err_valid     <= err_pend;
            if (err_pend) err_code <= err_pend_code;

            if (do_rd && (rd_cnt != 16'hFFFF))     rd_cnt  <= rd_cnt + 16'd1;
            if (do_wr && (wr_cnt != 16'hFFFF))     wr_cnt  <= wr_cnt + 16'd1;
            if (err_pend && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule
